// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue redirect, imem and decode handshake bundle
//
// Purpose: groups the redirect input, the instruction-memory request/grant/response
// channel and the decode valid/ready channel of if_fetch_queue.
// Ports (signals):
//   i_redirect, i_redirect_pc        redirect request and target
//   o_imem_req, o_imem_addr          memory request valid and word address
//   i_imem_gnt                       request accepted when o_imem_req & i_imem_gnt
//   i_imem_rvalid, i_imem_rdata      in-order memory response
//   o_valid, o_inst, o_pc            head of prefetch queue to decode
//   i_ready                          decode accepts head
// Modports: master = fetch queue, slave = surrounding core / memory.

interface if_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;
    logic            o_valid;
    logic [31:0]     o_inst;
    logic [XLEN-1:0] o_pc;
    logic            i_ready;

    modport master (
        input  i_redirect,
        input  i_redirect_pc,
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata,
        output o_valid,
        output o_inst,
        output o_pc,
        input  i_ready
    );

    modport slave (
        output i_redirect,
        output i_redirect_pc,
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata,
        input  o_valid,
        input  o_inst,
        input  o_pc,
        output i_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - in-order instruction prefetch queue with redirect
//
// Purpose: issues sequential word fetches to an instruction memory with
// variable, in-order response latency, buffers returned instructions with
// their PCs in a DEPTH-entry queue, and hands them to decode with valid/ready.
// Redirects reload the fetch PC, flush the queue and discard stale responses.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-high reset
//   bus      if_fetch_queue_if.master (redirect, imem channel, decode channel)

module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    if_fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc;

    // PCs of requests granted but not yet answered; occupancy equals outstanding.
    logic [XLEN-1:0] pend_mem [DEPTH];
    logic [AW-1:0]   pend_wr;
    logic [AW-1:0]   pend_rd;

    // Prefetch queue of {pc, instruction}.
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];
    logic [AW-1:0]   q_wr;
    logic [AW-1:0]   q_rd;

    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;

    logic            credit_ok;
    logic            req;
    logic            hs;
    logic            rsp;
    logic            keep;
    logic            pop;
    logic [XLEN-1:0] redirect_target;

    // Every buffered entry and every in-flight request holds a credit, so the
    // queue can never overflow no matter how responses bunch up.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    assign req       = !i_reset && !bus.i_redirect && credit_ok;
    assign hs        = req && bus.i_imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp       = bus.i_imem_rvalid && (outstanding != '0);
    // A response is kept only if it belongs to the current fetch stream.
    assign keep      = rsp && (drop_cnt == '0) && !bus.i_redirect;
    assign pop       = (count != '0) && bus.i_ready && !bus.i_redirect;

    assign redirect_target = bus.i_redirect_pc & ~XLEN'(3);

    assign bus.o_imem_req  = req;
    assign bus.o_imem_addr = fetch_pc;
    assign bus.o_valid     = (count != '0);
    assign bus.o_inst      = (count != '0) ? q_inst[q_rd] : NOP;
    assign bus.o_pc        = (count != '0) ? q_pc[q_rd]   : '0;

    // Storage arrays carry no reset; their contents are qualified by the pointers.
    always_ff @(posedge i_clk) begin
        if (hs) begin
            pend_mem[pend_wr] <= fetch_pc;
        end
        if (keep) begin
            q_pc[q_wr]   <= pend_mem[pend_rd];
            q_inst[q_wr] <= bus.i_imem_rdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_pc    <= RESET_PC;
            pend_wr     <= '0;
            pend_rd     <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (hs) begin
                pend_wr  <= pend_wr + AW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            // Stale responses still retire their pending PC to keep the FIFO aligned.
            if (rsp) begin
                pend_rd <= pend_rd + AW'(1);
            end

            case ({hs, rsp})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (bus.i_redirect) begin
                fetch_pc <= redirect_target;
                q_wr     <= '0;
                q_rd     <= '0;
                count    <= '0;
                // Everything still in flight is stale; a response arriving now
                // is discarded immediately and needs no further dropping.
                drop_cnt <= outstanding - CW'(rsp);
            end else begin
                if (keep) begin
                    q_wr <= q_wr + AW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + AW'(1);
                end
                case ({keep, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (rsp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end
endmodule
